ufp_resize_arbiter: RTL and testbench
=====================================

# ufp_resize_arbiter

Round-robin arbiter that shares one unsigned fixed-point resize datapath among `NREQ` requesters. Each requester presents a raw value in `IN_IW.IN_QW` format with a per-request clip/wrap mode. The block returns the result in `OUT_IW.OUT_QW` format through a single registered valid/ready output stage. It tags each result with the requester index and keeps a saturating count of overflow events. It sits between fixed-point producers (shading and colour stages) and a consumer that needs a narrower format.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, ≥2.
- `IN_IW`, 8: input integer bits.
- `IN_QW`, 8: input fraction bits.
- `OUT_IW`, 4: output integer bits.
- `OUT_QW`, 4: output fraction bits.
- `CNT_W`, 16: overflow counter width.
- `IDW`, derived as `$clog2(NREQ)`: requester index width.

Ports:
- `clk`  in  1  clock; the block has one clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NREQ  per-requester valid.
- `req_ready`  out  NREQ  per-requester accept.
- `req_data`  in  NREQ*(IN_IW+IN_QW)  packed raw inputs; requester i occupies slice i.
- `req_clip`  in  NREQ  per-requester mode: 1 saturates on overflow, 0 wraps.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accept.
- `out_data`  out  OUT_IW+OUT_QW  resized raw value.
- `out_clipping`  out  1  overflow was detected for this result.
- `out_id`  out  IDW  index of the requester that produced this result.
- `clip_count`  out  CNT_W  saturating count of accepted results with overflow.
- `clip_count_clr`  in  1  synchronous clear of `clip_count`.

## Operation
- **Stage free:** the output stage is free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in the same cycle.
- **Grant:**
  - Exactly one request is granted per cycle, combinationally.
  - The grant goes to the first requester with `req_valid`=1, searching from `ptr+1` upward and wrapping modulo NREQ.
  - `req_ready[i]` = (grant==i) AND stage free. All other ready bits are 0.
- **Transfer and pointer:** a transfer occurs when `req_valid[i]` and `req_ready[i]` are both 1. On a transfer, `ptr` becomes i. `ptr` holds when there is no transfer.
- **Requester rule:** a requester must hold `req_valid`, `req_data` and `req_clip` stable until it is accepted.
- **Fraction resize:**
  - If OUT_QW < IN_QW, the (IN_QW−OUT_QW) low fraction bits are truncated.
  - Otherwise the fraction is zero-padded at the LSB end.
- **Integer resize:**
  - If OUT_IW ≥ IN_IW, the integer part is zero-extended and overflow is 0.
  - Otherwise, overflow = OR of the dropped high integer bits.
  - With overflow=1 and clip=1, the result is all ones.
  - With overflow=1 and clip=0, the low OUT_IW integer bits are kept.
- **Clipping flag:** `out_clipping` equals overflow in both modes.
- **Output register:** on a transfer, `out_data`, `out_clipping` and `out_id` load and `out_valid` is set to 1.
- **Output hold:** while `out_valid`=1 and `out_ready`=0, all output fields hold stable.
- **Output drain:** when the output is accepted with no new transfer, `out_valid` clears to 0.
- **Overflow counter:**
  - `clip_count` increments by 1 on each transfer whose overflow=1.
  - The counter saturates at 2^CNT_W−1.
  - `clip_count_clr` takes priority over an increment in the same cycle; the result is 0.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_clipping`=0, `out_id`=0, `clip_count`=0, `ptr`=NREQ−1 (so requester 0 wins first), `req_ready`=0.
- **Reset mid-operation:** reset discards any held result. Requesters whose request was pending but not accepted must re-present it after reset.
- **Latency:** 1 cycle. Data accepted at edge N appears at `out_*` after edge N.
- **Throughput:** 1 result per cycle while `out_ready`=1.
- **Combinational paths:** `req_ready` depends combinationally on `req_valid` and `out_ready`. There is no combinational path from `req_data` to `out_*`.
- **Stalls:** with a full stage and `out_ready`=0, all `req_ready` bits are 0.

## Test plan
- **Resize values** (8.8→4.4, requester 0 only):
  - `req_data`=0x0A5C → `out_data`=0xA5, `out_clipping`=0.
  - `req_data`=0x1234, clip=1 → 0xFF, `out_clipping`=1.
  - `req_data`=0x1234, clip=0 → 0x23, `out_clipping`=1.
- **Round robin:** all 4 requesters valid continuously with `out_ready`=1 → `out_id` sequence 0,1,2,3,0,1; exactly one `req_ready` bit high per cycle.
- **Sparse requesters:** only requesters 1 and 3 valid → alternating `out_id` 1,3,1,3. Dropping requester 3 → `out_id` 1 every cycle with no bubble.
- **Backpressure:** `out_ready`=0 for 3 cycles with a result held → `out_data`/`out_id` stable, `req_ready`=0. Raising `out_ready` → the next result appears the following cycle.
- **Counter:**
  - Five overflowing transfers → `clip_count`=5.
  - Force `CNT_W`=2 and send 4 overflows → `clip_count` stays at 3.
  - Clear in the same cycle as an overflow transfer → `clip_count`=0.
- **Reset mid-stream:** assert `rst` while `out_valid`=1 → `out_valid`=0 and `clip_count`=0 immediately. After release, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/ufp_resize_arbiter.sv
// Round-robin arbiter sharing one unsigned fixed-point resize stage among NREQ
// requesters, with a registered valid/ready output and a saturating overflow counter.
module ufp_resize_arbiter #(
  parameter int NREQ   = 4,
  parameter int IN_IW  = 8,
  parameter int IN_QW  = 8,
  parameter int OUT_IW = 4,
  parameter int OUT_QW = 4,
  parameter int CNT_W  = 16,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*(IN_IW+IN_QW)-1:0]   req_data,
  input  logic [NREQ-1:0]                 req_clip,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_IW+OUT_QW-1:0]        out_data,
  output logic                            out_clipping,
  output logic [IDW-1:0]                  out_id,
  output logic [CNT_W-1:0]                clip_count,
  input  logic                            clip_count_clr
);

  localparam int IW = IN_IW + IN_QW;
  localparam int OW = OUT_IW + OUT_QW;

  logic [IW-1:0]     data_arr_s [NREQ];
  logic [IW-1:0]     sel_data_s;
  logic              sel_clip_s;
  logic [IN_IW-1:0]  in_int_s;
  logic [IN_QW-1:0]  in_frac_s;
  logic [OUT_IW-1:0] int_s;
  logic [OUT_QW-1:0] frac_s;
  logic              ovf_s;
  logic [OW-1:0]     res_s;

  logic              grant_found_s;
  logic [IDW-1:0]    grant_idx_s;
  logic              stage_free_s;
  logic              transfer_s;

  logic              out_valid_q, out_valid_d;
  logic [OW-1:0]     out_data_q, out_data_d;
  logic              out_clip_q, out_clip_d;
  logic [IDW-1:0]    out_id_q, out_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0]    ptr_q, ptr_d;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr_s[gi] = req_data[gi*IW +: IW];
  end

  // Search from ptr+1 upward, wrapping, for the first valid requester.
  always_comb begin : p_grant
    logic [IDW-1:0] cand;
    grant_found_s = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!grant_found_s && req_valid[cand]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand;
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  assign stage_free_s = !out_valid_q || out_ready;
  assign transfer_s   = grant_found_s && stage_free_s;
  assign req_ready    = (transfer_s && !rst) ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s)
                                             : {NREQ{1'b0}};

  assign sel_data_s = data_arr_s[grant_idx_s];
  assign sel_clip_s = req_clip[grant_idx_s];
  assign in_int_s   = sel_data_s[IW-1:IN_QW];
  assign in_frac_s  = sel_data_s[IN_QW-1:0];

  if (OUT_QW < IN_QW) begin : g_frac_trunc
    assign frac_s = in_frac_s[IN_QW-1 -: OUT_QW];
  end else begin : g_frac_pad
    assign frac_s = OUT_QW'(in_frac_s) << (OUT_QW - IN_QW);
  end

  if (OUT_IW >= IN_IW) begin : g_int_ext
    assign int_s = OUT_IW'(in_int_s);
    assign ovf_s = 1'b0;
  end else begin : g_int_narrow
    // Wrap keeps the low integer bits; any dropped high bit set is an overflow.
    assign int_s = in_int_s[OUT_IW-1:0];
    assign ovf_s = |in_int_s[IN_IW-1:OUT_IW];
  end

  assign res_s = (ovf_s && sel_clip_s) ? {OW{1'b1}} : {int_s, frac_s};

  // Next state for the output stage, round-robin pointer and overflow counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_clip_d  = out_clip_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (transfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = res_s;
      out_clip_d  = ovf_s;
      out_id_d    = grant_idx_s;
      ptr_d       = grant_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (clip_count_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (transfer_s && ovf_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; ptr resets to the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {OW{1'b0}};
      out_clip_q  <= 1'b0;
      out_id_q    <= {IDW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ptr_q       <= IDW'(NREQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_clip_q  <= out_clip_d;
      out_id_q    <= out_id_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_clipping = out_clip_q;
  assign out_id       = out_id_q;
  assign clip_count   = cnt_q;

endmodule

// File: tb/tb_ufp_resize_arbiter.sv
// Directed bench for ufp_resize_arbiter: 8.8->4.4 resize, round robin, backpressure,
// counter saturation (second instance with a 2-bit counter) and reset mid-stream.
module tb_ufp_resize_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready, req_ready_sm;
  logic [63:0] req_data;
  logic [3:0]  req_clip;
  logic        out_valid, out_valid_sm;
  logic        out_ready;
  logic [7:0]  out_data, out_data_sm;
  logic        out_clipping, out_clipping_sm;
  logic [1:0]  out_id, out_id_sm;
  logic [15:0] clip_count;
  logic [1:0]  clip_count_sm;
  logic        clip_count_clr;

  int checks = 0;
  int errors = 0;

  ufp_resize_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_clip(req_clip), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_clipping(out_clipping),
    .out_id(out_id), .clip_count(clip_count), .clip_count_clr(clip_count_clr)
  );

  ufp_resize_arbiter #(.CNT_W(2)) dut_sm (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_sm),
    .req_data(req_data), .req_clip(req_clip), .out_valid(out_valid_sm),
    .out_ready(out_ready), .out_data(out_data_sm), .out_clipping(out_clipping_sm),
    .out_id(out_id_sm), .clip_count(clip_count_sm), .clip_count_clr(clip_count_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] d, input logic c);
    req_data[i*16 +: 16] = d;
    req_clip[i]          = c;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_data = 64'h0; req_clip = 4'b0000;
    out_ready = 1'b1; clip_count_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_id", out_id, 2'd0);
    chk("rst_clipping", out_clipping, 1'b0);
    chk("rst_count", clip_count, 16'd0);
    chk("rst_ready", req_ready, 4'b0000);
    req_valid = 4'b0000;
    rst = 1'b0;
    #1;

    // resize values on requester 0
    set_req(0, 16'h0A5C, 1'b0); req_valid = 4'b0001;
    #1 chk("rz_ready", req_ready, 4'b0001);
    tick();
    chk("rz0_valid", out_valid, 1'b1);
    chk("rz0_data", out_data, 8'hA5);
    chk("rz0_clip", out_clipping, 1'b0);
    chk("rz0_id", out_id, 2'd0);
    set_req(0, 16'h1234, 1'b1);
    tick();
    chk("rz1_data", out_data, 8'hFF);
    chk("rz1_clip", out_clipping, 1'b1);
    set_req(0, 16'h1234, 1'b0);
    tick();
    chk("rz2_data", out_data, 8'h23);
    chk("rz2_clip", out_clipping, 1'b1);
    chk("rz_count", clip_count, 16'd2);
    chk("rz_count_sm", clip_count_sm, 2'd2);

    // three more overflows: total 5, small counter saturates at 3
    set_req(0, 16'h1234, 1'b1);
    tick(); tick(); tick();
    chk("cnt5", clip_count, 16'd5);
    chk("cnt_sat", clip_count_sm, 2'd3);
    chk("cnt_data", out_data, 8'hFF);

    // clear wins over a same-cycle overflow increment
    clip_count_clr = 1'b1;
    tick();
    chk("clr_count", clip_count, 16'd0);
    chk("clr_count_sm", clip_count_sm, 2'd0);
    chk("clr_clip", out_clipping, 1'b1);
    clip_count_clr = 1'b0; req_valid = 4'b0000;
    tick();
    chk("drain_valid", out_valid, 1'b0);

    // backpressure on requester 2
    set_req(2, 16'h0300, 1'b0); req_valid = 4'b0100;
    #1 chk("bp_ready0", req_ready, 4'b0100);
    tick();
    chk("bp_data0", out_data, 8'h30);
    chk("bp_id0", out_id, 2'd2);
    out_ready = 1'b0; set_req(2, 16'h0400, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_stall_ready", req_ready, 4'b0000);
      tick();
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_data", out_data, 8'h30);
      chk("bp_hold_id", out_id, 2'd2);
    end
    out_ready = 1'b1;
    #1 chk("bp_ready1", req_ready, 4'b0100);
    tick();
    chk("bp_data1", out_data, 8'h40);
    chk("bp_id1", out_id, 2'd2);
    req_valid = 4'b0000;
    tick();
    chk("bp_drain", out_valid, 1'b0);

    // sparse: requesters 1 and 3; ptr is 2 so 3 goes first
    set_req(1, 16'h0100, 1'b0); set_req(3, 16'h1234, 1'b1); req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sp_id", out_id, (k % 2 == 0) ? 2'd3 : 2'd1);
      chk("sp_data", out_data, (k % 2 == 0) ? 8'hFF : 8'h10);
    end
    req_valid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("sp1_valid", out_valid, 1'b1);
      chk("sp1_id", out_id, 2'd1);
    end
    chk("sp_count", clip_count, 16'd2);

    // asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_count", clip_count, 16'd0);
    chk("mrst_ready", req_ready, 4'b0000);
    for (int i = 0; i < 4; i++) set_req(i, 16'((i + 1) * 256), 1'b0);
    req_valid = 4'b1111;
    tick(); tick();
    rst = 1'b0;

    // round robin with all requesters valid
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_ready", req_ready, 32'(1) << (k % 4));
      tick();
      chk("rr_id", out_id, k % 4);
      chk("rr_data", out_data, ((k % 4) + 1) * 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
